ac_seq_mult8: RTL

Sequential 8x8 unsigned shift-add multiplier that acts as the driving side of the 8-bit NAND-chain carry lookahead unit.
- Forms generate/propagate terms from its accumulator and multiplicand, and presents them with `c0` to the CLU.
- Waits a fixed number of cycles for the asynchronous carry chain to settle, then consumes `c[8:1]` to form each partial sum.
- Sits between the datapath control (start/done handshake) and the combinational CLU instance.

---
 rtl/ac_seq_mult8_if.sv | 24 ++
 rtl/ac_seq_mult8.sv | 122 ++++++++++++
 2 files changed

// File: rtl/ac_seq_mult8_if.sv
// Handshake and CLU bundle for the ac_seq_mult8 shift-add multiplier.
// master = controller/CLU side, slave = multiplier side.
interface ac_seq_mult8_if;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [7:0]  g_n;
  logic [7:0]  p;
  logic        c0;
  logic [8:1]  c;

  modport master (
    output start, a, b, c,
    input  busy, done, product, g_n, p, c0
  );

  modport slave (
    input  start, a, b, c,
    output busy, done, product, g_n, p, c0
  );
endinterface

// File: rtl/ac_seq_mult8.sv
// 8x8 unsigned shift-add multiplier driving an external NAND-chain CLU.
// Optional AC_MULT_EARLY_EXIT_EN: finish once remaining multiplier bits are 0.
module ac_seq_mult8 #(
  parameter int SETTLE_CYCLES = 12
) (
  input  logic           clk,
  input  logic           reset,
  ac_seq_mult8_if.slave  io
);

  localparam int SCW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(SETTLE_CYCLES - 1);

`ifdef AC_MULT_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      a_q, a_d;
  logic [7:0]      q_q, q_d;
  logic [7:0]      m_q, m_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [SCW-1:0]  sc_q, sc_d;
  logic [15:0]     prod_q, prod_d;

  logic [7:0]      sum;
  logic            cout;
  logic [15:0]     aq_nx;
  logic            step_end;
  logic            rem_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      sc_q    <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      sc_q    <= sc_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    q_d      = q_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    sc_d     = sc_q;
    prod_d   = prod_q;
    sum      = io.p ^ {io.c[7:1], io.c0};
    cout     = io.c[8];
    aq_nx    = {a_q, q_q};
    step_end = 1'b0;
    rem_zero = (q_q & (8'hFF >> cnt_q)) == 8'h00;
    unique case (state_q)
      S_IDLE: begin
        if (io.start) begin
          m_d     = io.a;
          q_d     = io.b;
          a_d     = '0;
          cnt_d   = '0;
          sc_d    = '0;
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        if (EARLY_EXIT && rem_zero) begin
          prod_d  = {a_q, q_q} >> (4'd8 - cnt_q);
          state_d = S_DONE;
        end else if (!q_q[0]) begin
          aq_nx    = {1'b0, a_q, q_q[7:1]};
          step_end = 1'b1;
        end else if (sc_q == SC_LAST) begin
          // carries have had SETTLE_CYCLES edges to ripple through the CLU
          aq_nx    = {cout, sum, q_q[7:1]};
          step_end = 1'b1;
          sc_d     = '0;
        end else begin
          sc_d = sc_q + 1'b1;
        end
        if (step_end) begin
          {a_d, q_d} = aq_nx;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == 4'd7) begin
            prod_d  = aq_nx;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    io.busy    = state_q != S_IDLE;
    io.done    = state_q == S_DONE;
    io.product = prod_q;
    io.g_n     = ~(a_q & m_q);
    io.p       = a_q ^ m_q;
    io.c0      = 1'b0;
  end

endmodule
